// File: rtl/dmem_mmio.sv
`timescale 1ns/1ps
// Data-side memory for the single-cycle core: word RAM plus a small IO page
// (TX byte FIFO, status, free-running cycle counter, GPIO).
module dmem_mmio #(
    parameter int DEPTH_WORDS = 64,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        MemWrite,
    input  logic [31:0] ALUResult,
    input  logic [31:0] WriteData,
    output logic [31:0] ReadData,
    output logic        tx_valid,
    output logic [7:0]  tx_data,
    input  logic        tx_ready,
    output logic [31:0] gpio_out
);
    localparam int AW = $clog2(DEPTH_WORDS);
    localparam int FW = $clog2(FIFO_DEPTH);
    localparam logic [FW:0] CNT_FULL = (FW+1)'(FIFO_DEPTH);

    logic [31:0]   ram [DEPTH_WORDS];
    logic [AW-1:0] ram_idx;
    logic          is_io;
    logic [13:0]   io_word;
    logic          sel_tx, sel_status, sel_cycle, sel_gpio;
    logic          wr_en;

    logic [7:0]    fifo_mem [FIFO_DEPTH];
    logic [FW-1:0] rd_ptr, wr_ptr;
    logic [FW:0]   count;
    logic          empty, full;
    logic          pop, push_req, push_ok, ovf_set, ovf_clr;
    logic          overflow;
    logic [31:0]   cycle_cnt, cycle_nxt;
    logic [31:0]   gpio_q;
    logic          unused_addr_lsbs;

    // Word access only: the byte-lane bits of the address play no part.
    assign unused_addr_lsbs = ^ALUResult[1:0];

    assign ram_idx    = ALUResult[AW+1:2];
    assign is_io      = (ALUResult[31:16] == 16'hFFFF);
    assign io_word    = ALUResult[15:2];
    assign sel_tx     = is_io && (io_word == 14'd0);
    assign sel_status = is_io && (io_word == 14'd1);
    assign sel_cycle  = is_io && (io_word == 14'd2);
    assign sel_gpio   = is_io && (io_word == 14'd3);
    assign wr_en      = MemWrite && !rst;

    assign empty    = (count == '0);
    assign full     = (count == CNT_FULL);
    assign tx_valid = !empty;
    assign tx_data  = empty ? 8'h00 : fifo_mem[rd_ptr];
    assign gpio_out = gpio_q;

    // A pop frees a slot on the same edge, so a push into a full FIFO still lands.
    assign pop      = tx_valid && tx_ready;
    assign push_req = wr_en && sel_tx;
    assign push_ok  = push_req && (!full || pop);
    assign ovf_set  = push_req && full && !pop;
    assign ovf_clr  = wr_en && sel_status && WriteData[2];

    assign cycle_nxt = cycle_cnt + 32'd1;

    always_ff @(posedge clk) begin
        if (wr_en && !is_io) begin
            ram[ram_idx] <= WriteData;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) begin
            fifo_mem[wr_ptr] <= WriteData[7:0];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr    <= '0;
            wr_ptr    <= '0;
            count     <= '0;
            overflow  <= 1'b0;
            cycle_cnt <= '0;
            gpio_q    <= '0;
        end else begin
            cycle_cnt <= cycle_nxt;
            if (push_ok) begin
                wr_ptr <= wr_ptr + FW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + FW'(1);
            end
            case ({push_ok, pop})
                2'b10:   count <= count + (FW+1)'(1);
                2'b01:   count <= count - (FW+1)'(1);
                default: count <= count;
            endcase
            if (ovf_set) begin
                overflow <= 1'b1;
            end else if (ovf_clr) begin
                overflow <= 1'b0;
            end
            if (wr_en && sel_gpio) begin
                gpio_q <= WriteData;
            end
        end
    end

    always_comb begin
        ReadData = '0;
        if (!is_io) begin
            ReadData = ram[ram_idx];
        end else if (sel_status) begin
            ReadData = {29'b0, overflow, full, empty};
        end else if (sel_cycle) begin
            ReadData = cycle_cnt;
        end else if (sel_gpio) begin
            ReadData = gpio_q;
        end
    end

endmodule

// File: tb/tb_dmem_mmio.sv
`timescale 1ns/1ps
// Directed bench for dmem_mmio: expected values queued as stimulus is driven,
// popped and compared when the DUT output is sampled on the falling edge.
module tb_dmem_mmio;
    localparam int DEPTH = 64;
    localparam logic [31:0] A_TX     = 32'hFFFF_0000;
    localparam logic [31:0] A_STATUS = 32'hFFFF_0004;
    localparam logic [31:0] A_CYCLE  = 32'hFFFF_0008;
    localparam logic [31:0] A_GPIO   = 32'hFFFF_000C;
    localparam logic [31:0] A_UNMAP  = 32'hFFFF_0020;

    logic        clk = 1'b0;
    logic        rst;
    logic        MemWrite;
    logic [31:0] ALUResult;
    logic [31:0] WriteData;
    logic [31:0] ReadData;
    logic        tx_valid;
    logic [7:0]  tx_data;
    logic        tx_ready;
    logic [31:0] gpio_out;

    int n_tests = 0;
    int n_fail  = 0;
    logic [31:0] exp_q[$];
    logic [7:0]  tx_exp[$];
    logic [31:0] m_cyc;
    logic [31:0] k_cyc;

    dmem_mmio #(.DEPTH_WORDS(DEPTH), .FIFO_DEPTH(4)) dut (
        .clk(clk), .rst(rst), .MemWrite(MemWrite), .ALUResult(ALUResult),
        .WriteData(WriteData), .ReadData(ReadData), .tx_valid(tx_valid),
        .tx_data(tx_data), .tx_ready(tx_ready), .gpio_out(gpio_out)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (rst) m_cyc <= 32'd0;
        else     m_cyc <= m_cyc + 32'd1;
    end

    task automatic check(input string tag, input logic [31:0] obs);
        logic [31:0] e;
        n_tests++;
        if (exp_q.size() == 0) begin
            n_fail++;
            $error("FAIL %s: observed=%h, no expected value queued", tag, obs);
        end else begin
            e = exp_q.pop_front();
            assert (obs === e) else begin
                n_fail++;
                $error("FAIL %s: observed=%h expected=%h", tag, obs, e);
            end
        end
    endtask

    task automatic expect_sig(input string tag, input logic [31:0] exp_v, input logic [31:0] obs);
        exp_q.push_back(exp_v);
        check(tag, obs);
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        MemWrite = 1'b1; ALUResult = a; WriteData = d;
        step();
        MemWrite = 1'b0;
    endtask

    task automatic rd(input string tag, input logic [31:0] a, input logic [31:0] exp_v);
        MemWrite = 1'b0; ALUResult = a;
        exp_q.push_back(exp_v);
        #1;
        check(tag, ReadData);
    endtask

    task automatic push(input logic [7:0] b, input bit accepted);
        if (accepted) tx_exp.push_back(b);
        wr(A_TX, {24'hA5A5A5, b});
    endtask

    task automatic drain(input string tag);
        int budget = 20;
        tx_ready = 1'b1;
        while (tx_exp.size() > 0 && budget > 0) begin
            if (tx_valid) begin
                exp_q.push_back({24'h0, tx_exp.pop_front()});
                check(tag, {24'h0, tx_data});
            end
            step();
            budget--;
        end
        if (tx_exp.size() != 0) begin
            n_tests++;
            n_fail++;
            $error("FAIL %s: drain timeout, %0d bytes outstanding, required 0", tag, tx_exp.size());
            tx_exp.delete();
        end
        tx_ready = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, required $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; MemWrite = 1'b0; ALUResult = '0; WriteData = '0; tx_ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);

        expect_sig("rst_tx_valid", 32'd0, {31'b0, tx_valid});
        expect_sig("rst_tx_data", 32'd0, {24'b0, tx_data});
        expect_sig("rst_gpio", 32'd0, gpio_out);
        rd("rst_status", A_STATUS, 32'h1);
        rd("rst_cycle", A_CYCLE, 32'h0);
        rst = 1'b0;

        // RAM: same-cycle read returns old data, alias and byte-offset reads.
        wr(32'h10, 32'h1111_1111);
        MemWrite = 1'b1; ALUResult = 32'h10; WriteData = 32'hDEAD_BEEF;
        exp_q.push_back(32'h1111_1111);
        #1;
        check("ram_same_cycle_old", ReadData);
        step();
        MemWrite = 1'b0;
        rd("ram_next_cycle", 32'h10, 32'hDEAD_BEEF);
        rd("ram_alias", 32'h10 + 32'(4 * DEPTH), 32'hDEAD_BEEF);
        rd("ram_byte_off", 32'h13, 32'hDEAD_BEEF);

        // GPIO and unmapped IO.
        wr(A_GPIO, 32'h1234_5678);
        expect_sig("gpio_out", 32'h1234_5678, gpio_out);
        rd("gpio_readback", A_GPIO, 32'h1234_5678);
        wr(32'h20, 32'hCAFE_F00D);
        wr(A_UNMAP, 32'hBADB_AD00);
        rd("unmapped_read", A_UNMAP, 32'h0);
        rd("ram_word8_intact", 32'h20, 32'hCAFE_F00D);

        // TX order, full, overflow, drain, overflow clear.
        push(8'h41, 1); push(8'h42, 1); push(8'h43, 1); push(8'h44, 1);
        rd("status_full", A_STATUS, 32'h2);
        rd("txdata_reads_zero", A_TX, 32'h0);
        expect_sig("head_held", 32'h41, {24'b0, tx_data});
        push(8'h45, 0);
        rd("status_overflow", A_STATUS, 32'h6);
        drain("drain_order");
        expect_sig("drained_valid", 32'd0, {31'b0, tx_valid});
        rd("status_empty_ovf", A_STATUS, 32'h5);
        wr(A_STATUS, 32'h4);
        rd("status_ovf_clear", A_STATUS, 32'h1);

        // Full FIFO with push and pop on the same edge.
        push(8'h51, 1); push(8'h52, 1); push(8'h53, 1); push(8'h54, 1);
        tx_ready = 1'b1;
        tx_exp.pop_front();
        push(8'h55, 1);
        rd("status_pushpop_full", A_STATUS, 32'h2);
        drain("drain_pushpop");
        rd("status_pushpop_noovf", A_STATUS, 32'h1);

        // Cycle counter span and wrap.
        rd("cycle_k", A_CYCLE, m_cyc);
        k_cyc = m_cyc;
        repeat (10) step();
        rd("cycle_k_plus_10", A_CYCLE, k_cyc + 32'd10);
        force dut.cycle_nxt = 32'hFFFF_FFFF;
        step();
        release dut.cycle_nxt;
        rd("cycle_max", A_CYCLE, 32'hFFFF_FFFF);
        step();
        rd("cycle_wrap", A_CYCLE, 32'h0);

        // Reset mid-drain, with writes attempted while in reset.
        push(8'h61, 1); push(8'h62, 1); push(8'h63, 1);
        expect_sig("pre_rst_valid", 32'd1, {31'b0, tx_valid});
        rst = 1'b1; tx_ready = 1'b1;
        wr(32'h10, 32'h0BAD_F00D);
        rd("rst_ram_visible", 32'h10, 32'hDEAD_BEEF);
        rd("rst_gpio_read", A_GPIO, 32'h0);
        MemWrite = 1'b1; ALUResult = A_GPIO; WriteData = 32'hFFFF_FFFF;
        step();
        ALUResult = A_TX; WriteData = 32'h77;
        step();
        MemWrite = 1'b0; rst = 1'b0; tx_ready = 1'b0;
        tx_exp.delete();
        expect_sig("post_rst_valid", 32'd0, {31'b0, tx_valid});
        expect_sig("post_rst_tx_data", 32'd0, {24'b0, tx_data});
        expect_sig("post_rst_gpio", 32'd0, gpio_out);
        rd("post_rst_status", A_STATUS, 32'h1);
        rd("post_rst_cycle", A_CYCLE, 32'h0);
        rd("post_rst_ram", 32'h10, 32'hDEAD_BEEF);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/dmem_mmio.md
Name: dmem_mmio

Overview:
Memory-side responder for the single-cycle ARM core's data port. It accepts MemWrite, ALUResult (address) and WriteData from the core, and returns ReadData combinationally in the same cycle. Contents:
- word RAM
- small memory-mapped I/O page: byte TX FIFO with valid/ready drain, status register, free-running cycle counter, GPIO output register.

Parameters:
DEPTH_WORDS, 64, number of 32-bit RAM words; power of two, minimum 4.
FIFO_DEPTH, 4, TX FIFO entries; power of two, minimum 2.

Ports:
clk  input  1  clock; all state updates on rising edge
rst  input  1  synchronous reset, active-high
MemWrite  input  1  write strobe from core, qualified by ALUResult
ALUResult  input  32  byte address from core
WriteData  input  32  store data from core
ReadData  output  32  load data to core, combinational from ALUResult
tx_valid  output  1  TX FIFO head valid
tx_data  output  8  TX FIFO head byte
tx_ready  input  1  sink accepts head when tx_valid && tx_ready
gpio_out  output  32  GPIO register value

Behaviour:
- Decode: IO page when ALUResult[31:16]==16'hFFFF, else RAM. ALUResult[1:0] ignored everywhere (word access only).
- RAM index = ALUResult[log2(DEPTH_WORDS)+1:2].
  - Higher RAM address bits ignored, so addresses alias.
  - RAM is not reset; contents survive rst.
- RAM read is asynchronous. RAM write happens at the clock edge when MemWrite=1.
- Read of the address being written in the same cycle returns the old data; the new data is visible the next cycle.
- IO map (offset = ALUResult[15:0]):
  - 0x0000 TXDATA: write pushes WriteData[7:0]; read returns 0.
  - 0x0004 STATUS: read {29'b0, overflow, full, empty}. Write with WriteData[2]=1 clears overflow; other bits are read-only.
  - 0x0008 CYCLE: read returns counter; writes ignored.
  - 0x000C GPIO: read/write 32-bit, drives gpio_out.
  - Any other IO offset: read 0, write ignored. IO writes never touch RAM.
- Cycle counter: 32-bit, 0 after reset, +1 every non-reset cycle, wraps 0xFFFFFFFF->0.
- All IO reads reflect register state before the current edge.
- TX FIFO: registered, no fall-through.
  - A byte pushed at edge N is at the head at earliest at cycle N+1.
  - pop = tx_valid && tx_ready, checked at each edge.
  - tx_valid = !empty; tx_data = head entry, held stable while tx_valid && !tx_ready.
- FIFO boundary cases:
  - Push when not full: accepted.
  - Push when full with pop the same edge: accepted, count unchanged.
  - Push when full without pop: byte dropped, overflow set (sticky).
  - Push when empty: accepted; no pop possible that edge.
  - Overflow set and clear at the same edge: set wins.
- Pointers wrap modulo FIFO_DEPTH. Count is tracked with an extra bit so full and empty are distinct.
- Reset (synchronous, any cycle, including mid-drain):
  - FIFO emptied; tx_valid=0; tx_data=0 when empty.
  - overflow=0, counter=0, gpio_out=0.
  - MemWrite during rst is ignored for both RAM and IO.
  - ReadData is still combinational during reset: RAM data, or reset-state IO values.
- No internal wait states: every access completes in one cycle, matching the single-cycle core.

Test Plan:
- RAM: write 0xDEADBEEF @0x10, read @0x10 same cycle -> old value; next cycle -> 0xDEADBEEF. Read @0x10+4*DEPTH_WORDS -> 0xDEADBEEF (alias). Read @0x13 -> same word.
- TX order/handshake: with tx_ready=0, push 0x41,0x42,0x43,0x44 -> after 4th push STATUS=0b010. Push 0x45 -> dropped, STATUS=0b110. Raise tx_ready -> bytes 0x41..0x44 drained in order over 4 cycles, then STATUS=0b101. Write STATUS 0x4 -> STATUS=0b001.
- Full with simultaneous push+pop: FIFO full, tx_ready=1, push 0x55 -> accepted, no overflow. Drain order ends with 0x55.
- Cycle counter: after rst deassert, read CYCLE at cycles k and k+10 -> difference 10. Force near-wrap run -> 0xFFFFFFFF followed by 0.
- GPIO and unmapped IO: write 0x12345678 to 0xFFFF000C -> gpio_out=0x12345678 next cycle, readback equal. Write to 0xFFFF0020 -> reads 0, RAM word 8 unchanged.
- Reset mid-drain: 3 bytes queued, tx_valid=1, assert rst one cycle -> tx_valid=0, STATUS=0b001, gpio_out=0, CYCLE=0 after release. RAM word at 0x10 still 0xDEADBEEF. MemWrite during rst has no effect.
